instr_encoder_writer: RTL and testbench

- Inverse of the core's instruction decoder. Accepts field-level instruction requests (kind, funct3, alt bit, rd, rs1, rs2, immediate) over a valid/ready handshake.
- Range-checks each request, packs it into a 32-bit RV32I word (or a word in the custom stdin/stdout format), and writes it into instruction memory at an auto-incrementing word address.
- Used by the boot/test-program loader to build programs in instruction memory.

---
 rtl/instr_encoder_writer.sv | 160 ++++++++++++++++
 tb/tb_instr_encoder_writer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_writer.sv
// Field-level RV32I (plus custom stdin/stdout) instruction encoder that range-checks
// each request and streams the packed word into instruction memory at an auto-incrementing address.
module instr_encoder_writer #(
    parameter int          ADDR_W    = 10,
    parameter logic [6:0]  OPCODE_IO = 7'b0001011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err_illegal
);

    localparam logic [3:0] K_OP     = 4'd0;
    localparam logic [3:0] K_OPIMM  = 4'd1;
    localparam logic [3:0] K_LOAD   = 4'd2;
    localparam logic [3:0] K_STORE  = 4'd3;
    localparam logic [3:0] K_BRANCH = 4'd4;
    localparam logic [3:0] K_JAL    = 4'd5;
    localparam logic [3:0] K_JALR   = 4'd6;
    localparam logic [3:0] K_LUI    = 4'd7;
    localparam logic [3:0] K_AUIPC  = 4'd8;
    localparam logic [3:0] K_STDIN  = 4'd9;
    localparam logic [3:0] K_STDOUT = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic signed [31:0] imm;
    logic               imm_s12, imm_u12, imm_sh, imm_b, imm_j, imm_u20;
    logic               alt_ok, legal, accept;
    logic [6:0]         funct7;
    logic [31:0]        word;

    logic               we_p1;
    logic [ADDR_W-1:0]  addr_p1;
    logic [31:0]        wdata_p1;
    logic               err_p1;
    logic [ADDR_W-1:0]  ptr;

    assign imm     = $signed(in_imm);
    assign imm_s12 = (imm >= -32'sd2048)    && (imm <= 32'sd2047);
    assign imm_u12 = (imm >= 32'sd0)        && (imm <= 32'sd4095);
    assign imm_sh  = (imm >= 32'sd0)        && (imm <= 32'sd31);
    assign imm_b   = (imm >= -32'sd4096)    && (imm <= 32'sd4095)    && !imm[0];
    assign imm_j   = (imm >= -32'sd1048576) && (imm <= 32'sd1048575) && !imm[0];
    assign imm_u20 = (imm >= -32'sd524288)  && (imm <= 32'sd524287);

    assign alt_ok = ((in_kind == K_OP) && ((in_funct3 == 3'b000) || (in_funct3 == 3'b101)))
                 || ((in_kind == K_OPIMM) && (in_funct3 == 3'b101));
    assign funct7 = in_alt ? 7'b0100000 : 7'b0000000;

    always_comb begin
        legal = !(in_alt && !alt_ok);
        word  = 32'd0;
        case (in_kind)
            K_OP: word = {funct7, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
            K_OPIMM: begin
                if ((in_funct3 == 3'b001) || (in_funct3 == 3'b101)) begin
                    if (!imm_sh) legal = 1'b0;
                    word = {funct7, imm[4:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
                end else begin
                    // SLTIU is zero-extended by the decoder, so it takes an unsigned range
                    if ((in_funct3 == 3'b011) ? !imm_u12 : !imm_s12) legal = 1'b0;
                    word = {imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
                end
            end
            K_LOAD: begin
                if (!imm_s12 || (in_funct3 == 3'b011) || (in_funct3 > 3'b101)) legal = 1'b0;
                word = {imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
            end
            K_STORE: begin
                if (!imm_s12 || (in_funct3 > 3'b010)) legal = 1'b0;
                word = {imm[11:5], in_rs2, in_rs1, in_funct3, imm[4:0], OPC_STORE};
            end
            K_BRANCH: begin
                if (!imm_b || (in_funct3 == 3'b010) || (in_funct3 == 3'b011)) legal = 1'b0;
                word = {imm[12], imm[10:5], in_rs2, in_rs1, in_funct3, imm[4:1], imm[11], OPC_BRANCH};
            end
            K_JAL: begin
                if (!imm_j) legal = 1'b0;
                word = {imm[20], imm[10:1], imm[11], imm[19:12], in_rd, OPC_JAL};
            end
            K_JALR: begin
                if (!imm_s12) legal = 1'b0;
                word = {imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
            end
            K_LUI: begin
                if (!imm_u20) legal = 1'b0;
                word = {imm[19:0], in_rd, OPC_LUI};
            end
            K_AUIPC: begin
                if (!imm_u20) legal = 1'b0;
                word = {imm[19:0], in_rd, OPC_AUIPC};
            end
            K_STDIN:  word = {7'd0, 5'd0, 5'd0, 3'b000, in_rd, OPCODE_IO};
            K_STDOUT: word = {7'd0, 5'd0, in_rs1, 3'b001, 5'd0, OPCODE_IO};
            default:  legal = 1'b0;
        endcase
    end

    assign in_ready = (!we_p1 || imem_ready) && !base_load;
    assign accept   = in_valid && in_ready;

    // Output stage: one pending word; a new one is taken only as the old one retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_p1    <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= 32'd0;
            err_p1   <= 1'b0;
            ptr      <= '0;
        end else if (base_load) begin
            we_p1  <= 1'b0;
            err_p1 <= 1'b0;
            ptr    <= base_addr;
        end else begin
            if (we_p1 && imem_ready)
                ptr <= ptr + ADDR_W'(1);
            if (accept) begin
                if (legal) begin
                    we_p1    <= 1'b1;
                    addr_p1  <= we_p1 ? ptr + ADDR_W'(1) : ptr;
                    wdata_p1 <= word;
                end else begin
                    we_p1  <= 1'b0;
                    err_p1 <= 1'b1;
                end
            end else if (imem_ready) begin
                we_p1 <= 1'b0;
            end
        end
    end

    assign imem_we     = we_p1;
    assign imem_addr   = addr_p1;
    assign imem_wdata  = wdata_p1;
    assign err_illegal = err_p1;

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Scoreboard bench for instr_encoder_writer: expected (addr, word) pairs are queued as
// requests are driven and retired by a monitor whenever the memory write handshake completes.
module tb_instr_encoder_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        base_load;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        imem_we;
    logic        imem_ready;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        err_illegal;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        sb[$];
    logic [9:0] exp_ptr;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    instr_encoder_writer #(.ADDR_W(10), .OPCODE_IO(7'b0001011)) dut (
        .clk(clk), .rst(rst), .base_load(base_load), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_funct3(in_funct3),
        .in_alt(in_alt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .err_illegal(err_illegal)
    );

    // Retire expected writes whenever the memory handshake completes
    always @(negedge clk) begin
        if (!rst && imem_we && imem_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %08h, required no write", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if ({imem_addr, imem_wdata} !== {e.addr, e.data}) begin
                    n_fail++;
                    $display("FAIL write: got addr %0d data %08h, required addr %0d data %08h",
                             imem_addr, imem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic send_nb(input logic [3:0] kind, input logic [2:0] f3, input logic alt,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input bit writes, input logic [31:0] exp_data);
        in_kind = kind; in_funct3 = f3; in_alt = alt;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        if (writes) begin
            sb.push_back('{addr: exp_ptr, data: exp_data});
            exp_ptr = exp_ptr + 10'd1;
        end
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: in_ready stayed %0b, required 1 within 50 cycles", in_ready);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] kind, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input bit writes, input logic [31:0] exp_data);
        send_nb(kind, f3, alt, rd, rs1, rs2, imm, writes, exp_data);
        wait_accept();
    endtask

    task automatic do_base(input logic [9:0] a);
        base_load = 1'b1; base_addr = a;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL base_in_ready: got %0b, required 0", in_ready);
        end
        @(posedge clk); #1;
        base_load = 1'b0; in_valid = 1'b0;
        exp_ptr = a;
        n_checks++;
        if ({imem_we, err_illegal} !== 2'b00) begin
            n_fail++; $display("FAIL base_clear: got we/err %b, required 00", {imem_we, err_illegal});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; base_load = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_kind = '0; in_funct3 = '0; in_alt = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; imem_ready = 1'b1; exp_ptr = '0;
        idle(3);
        n_checks++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, err_illegal} !== {1'b1, 1'b0, 10'd0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy %0b we %0b addr %0d data %08h err %0b, required 1 0 0 0 0",
                     in_ready, imem_we, imem_addr, imem_wdata, err_illegal);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_addi();
        send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h00500093);
        n_checks++;
        if ({imem_we, imem_addr} !== {1'b1, 10'd0}) begin
            n_fail++; $display("FAIL addi_latency: got we %0b addr %0d, required 1 0", imem_we, imem_addr);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        send(4'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,          1, 32'h402081B3);
        send(4'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          1, 32'h0020A423);
        send(4'd4, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC,   1, 32'hFE000EE3);
        send(4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,       1, 32'h001000EF);
        send(4'd7, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h00012345,   1, 32'h123452B7);
        send(4'd1, 3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,          1, 32'h40315093);
        send(4'd9, 3'b000, 1'b0, 5'd4, 5'd0, 5'd0, 32'd0,          1, 32'h0000020B);
        send(4'd10, 3'b000, 1'b0, 5'd0, 5'd7, 5'd0, 32'd0,         1, 32'h0003900B);
        idle(3);
    endtask

    task automatic test_illegal();
        send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 32'd0);
        n_checks++;
        if ({imem_we, err_illegal} !== 2'b01) begin
            n_fail++; $display("FAIL illegal_addi: got we/err %b, required 01", {imem_we, err_illegal});
        end
        send(4'd4, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd3, 0, 32'd0);
        send(4'd0, 3'b110, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 0, 32'd0);
        send(4'd1, 3'b011, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 0, 32'd0);
        n_checks++;
        if (err_illegal !== 1'b1) begin
            n_fail++; $display("FAIL illegal_sticky: got err %0b, required 1", err_illegal);
        end
        do_base(exp_ptr);
        send(4'd11, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0);
        n_checks++;
        if (err_illegal !== 1'b1) begin
            n_fail++; $display("FAIL illegal_kind: got err %0b, required 1", err_illegal);
        end
        do_base(exp_ptr);
        // SLTIU at the top of its unsigned range is still legal
        send(4'd1, 3'b011, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4095, 1, 32'hFFF03093);
        idle(2);
    endtask

    task automatic test_stall();
        logic [9:0] a0;
        a0 = exp_ptr;
        imem_ready = 1'b0;
        send(4'd1, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 1, 32'h00700113);
        send_nb(4'd1, 3'b000, 1'b0, 5'd3, 5'd0, 5'd0, 32'hFFFFFFFF, 1, 32'hFFF00193);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({in_ready, imem_we, imem_addr, imem_wdata} !== {1'b0, 1'b1, a0, 32'h00700113}) begin
                n_fail++;
                $display("FAIL stall_hold: got rdy %0b we %0b addr %0d data %08h, required 0 1 %0d 00700113",
                         in_ready, imem_we, imem_addr, imem_wdata, a0);
            end
        end
        @(posedge clk); #1;
        imem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: got in_ready %0b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        idle(2);
    endtask

    task automatic test_wrap();
        do_base(10'd1023);
        send(4'd1, 3'b000, 1'b0, 5'd1, 5'd1, 5'd0, 32'd1, 1, 32'h00108093);
        send(4'd1, 3'b000, 1'b0, 5'd1, 5'd1, 5'd0, 32'd1, 1, 32'h00108093);
        idle(2);
    endtask

    task automatic test_base_discard();
        imem_ready = 1'b0;
        send(4'd1, 3'b000, 1'b0, 5'd9, 5'd0, 5'd0, 32'd9, 0, 32'd0);
        send_nb(4'd1, 3'b000, 1'b0, 5'd8, 5'd0, 5'd0, 32'd8, 0, 32'd0);
        do_base(10'd100);
        imem_ready = 1'b1;
        idle(3);
        send(4'd6, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFFF800, 1, 32'h800100E7);
        idle(2);
    endtask

    task automatic test_reset_mid();
        imem_ready = 1'b0;
        send(4'd1, 3'b000, 1'b0, 5'd6, 5'd0, 5'd0, 32'd6, 0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, imem_we, err_illegal} !== 3'b100) begin
            n_fail++; $display("FAIL reset_mid: got rdy/we/err %b, required 100", {in_ready, imem_we, err_illegal});
        end
        @(posedge clk); #1;
        rst = 1'b0; imem_ready = 1'b1; exp_ptr = '0;
        send(4'd8, 3'b000, 1'b0, 5'd10, 5'd0, 5'd0, 32'h00001, 1, 32'h00001517);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_stall();
        test_wrap();
        test_base_discard();
        test_reset_mid();
        idle(3);
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++; $display("FAIL drain: got %0d pending expected writes, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
